// File: rtl/regex_instr_memory_responder.sv
// Instruction memory responder for the regex CPU fetch port.
// Serves one fetch at a time with a fixed read latency; the host loads the program through the load port.
module regex_instr_memory_responder #(
    parameter int MEMORY_WIDTH      = 16,
    parameter int MEMORY_ADDR_WIDTH = 11,
    parameter int MEMORY_DEPTH      = 2048,
    parameter int READ_LATENCY      = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         memory_valid,
    input  logic [MEMORY_ADDR_WIDTH-1:0] memory_addr,
    output logic                         memory_ready,
    output logic [MEMORY_WIDTH-1:0]      memory_data,
    input  logic                         load_valid,
    input  logic [MEMORY_ADDR_WIDTH-1:0] load_addr,
    input  logic [MEMORY_WIDTH-1:0]      load_data,
    output logic                         load_ready,
    output logic                         addr_error,
    output logic [15:0]                  fetch_count
);

    localparam int IDX_WIDTH = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
    localparam logic [MEMORY_ADDR_WIDTH:0] DEPTH_LIMIT =
        (MEMORY_ADDR_WIDTH + 1)'(MEMORY_DEPTH);
    localparam logic [3:0] LAT_INIT = 4'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESPOND
    } state_t;

    state_t                         state;
    state_t                         state_next;
    logic [3:0]                     lat_count;
    logic [3:0]                     lat_count_next;
    logic [MEMORY_ADDR_WIDTH-1:0]   fetch_addr;
    logic [MEMORY_ADDR_WIDTH-1:0]   fetch_addr_next;
    logic [MEMORY_WIDTH-1:0]        ram [MEMORY_DEPTH];
    logic [MEMORY_WIDTH-1:0]        ram_rdata;
    logic                           ram_write;
    logic                           fetch_done;
    logic                           load_bad;
    logic                           fetch_in_range;
    logic                           load_in_range;

    // Widen by one bit so a depth equal to 2**ADDR_WIDTH compares correctly
    assign fetch_in_range = {1'b0, fetch_addr} < DEPTH_LIMIT;
    assign load_in_range  = {1'b0, load_addr} < DEPTH_LIMIT;
    assign ram_rdata      = ram[fetch_addr[IDX_WIDTH-1:0]];

    always_comb begin
        state_next      = state;
        lat_count_next  = lat_count;
        fetch_addr_next = fetch_addr;
        load_ready      = 1'b0;
        memory_ready    = 1'b0;
        ram_write       = 1'b0;
        fetch_done      = 1'b0;
        load_bad        = 1'b0;
        unique case (state)
            S_IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    ram_write = load_in_range;
                    load_bad  = !load_in_range;
                end else if (memory_valid) begin
                    fetch_addr_next = memory_addr;
                    lat_count_next  = LAT_INIT;
                    state_next      = (LAT_INIT != 4'd0) ? S_WAIT : S_RESPOND;
                end
            end
            S_WAIT: begin
                if (!memory_valid) begin
                    state_next = S_IDLE;
                end else begin
                    lat_count_next = lat_count - 4'd1;
                    if (lat_count == 4'd1) state_next = S_RESPOND;
                end
            end
            S_RESPOND: begin
                memory_ready = memory_valid;
                fetch_done   = memory_valid;
                state_next   = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            lat_count   <= '0;
            fetch_addr  <= '0;
            memory_data <= '0;
            addr_error  <= 1'b0;
            fetch_count <= '0;
        end else begin
            state      <= state_next;
            lat_count  <= lat_count_next;
            fetch_addr <= fetch_addr_next;
            if (fetch_done) begin
                memory_data <= fetch_in_range ? ram_rdata : '0;
                fetch_count <= fetch_count + 16'd1;
            end
            if ((fetch_done && !fetch_in_range) || load_bad) addr_error <= 1'b1;
        end
    end

    // Program RAM survives reset
    always_ff @(posedge clk) begin
        if (ram_write) ram[load_addr[IDX_WIDTH-1:0]] <= load_data;
    end

endmodule
